// File: rtl/axis_frame_tx.sv
// Framed sample transmitter: sign-extends complex 16-bit samples, tags every
// FRAME_LEN-th sample with tlast, and buffers them in a small FIFO toward an AXI-Stream sink.
module axis_frame_tx #(
  parameter int unsigned FRAME_LEN  = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_re,
  input  logic [15:0] s_im,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic [31:0] m_tdata_re,
  output logic [31:0] m_tdata_im,
  output logic        m_tlast,
  output logic [15:0] frame_cnt
);

  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

  typedef struct packed {
    logic        last;
    logic [15:0] re;
    logic [15:0] im;
  } entry_t;

  entry_t        mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [15:0]   idx_q, idx_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          run_q;
  logic          push, pop;
  entry_t        head;

  always_comb begin
    // run_q keeps s_ready low while in reset even though the FIFO reads as empty
    s_ready    = run_q && (count_q != DEPTH_C);
    m_tvalid   = (count_q != '0);
    push       = s_valid && s_ready;
    pop        = m_tvalid && m_tready;
    head       = mem_q[rd_ptr_q];
    m_tdata_re = m_tvalid ? {{16{head.re[15]}}, head.re} : '0;
    m_tdata_im = m_tvalid ? {{16{head.im[15]}}, head.im} : '0;
    m_tlast    = m_tvalid && head.last;
    frame_cnt  = frame_cnt_q;

    wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d     = count_q + (AW+1)'(push) - (AW+1)'(pop);
    idx_d       = idx_q;
    if (push) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 16'd1;
    end
    frame_cnt_d = (pop && head.last) ? frame_cnt_q + 16'd1 : frame_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      frame_cnt_q <= '0;
      run_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
      run_q       <= 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible while count_q says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{last: (idx_q == LAST_IDX), re: s_re, im: s_im};
    end
  end

endmodule

// File: tb/tb_axis_frame_tx.sv
// Directed and randomized checks of axis_frame_tx with FRAME_LEN=4, FIFO_DEPTH=4.
module tb_axis_frame_tx;

  localparam int unsigned FL = 4;
  localparam int unsigned FD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        m_tready = 1'b0;
  logic [15:0] s_re = '0;
  logic [15:0] s_im = '0;
  logic        s_ready, m_tvalid, m_tlast;
  logic [31:0] m_tdata_re, m_tdata_im;
  logic [15:0] frame_cnt;

  axis_frame_tx #(.FRAME_LEN(FL), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im),
    .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tdata_re(m_tdata_re), .m_tdata_im(m_tdata_im),
    .m_tlast(m_tlast), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_miss = 0;
  logic [32:0] exp_q[$];   // {tlast, re16, im16}
  logic [64:0] out_log[$]; // {tlast, re32, im32} as observed
  int unsigned in_idx = 0;
  int unsigned n_out = 0;
  logic [15:0] model_fc = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called #1 after an edge with inputs already driven for the coming edge.
  task automatic step();
    logic        acc, pop;
    logic [32:0] e;
    acc = s_valid && s_ready;
    pop = m_tvalid && m_tready;
    check("m_tvalid", 32'(m_tvalid), 32'(exp_q.size() != 0));
    check("s_ready", 32'(s_ready), 32'(exp_q.size() != FD));
    if (pop && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("tdata_re", m_tdata_re, {{16{e[31]}}, e[31:16]});
      check("tdata_im", m_tdata_im, {{16{e[15]}}, e[15:0]});
      check("tlast", 32'(m_tlast), 32'(e[32]));
      out_log.push_back({m_tlast, m_tdata_re, m_tdata_im});
      n_out++;
      if (e[32]) model_fc = model_fc + 16'd1;
    end
    if (acc) begin
      exp_q.push_back({(in_idx == FL-1), s_re, s_im});
      in_idx = (in_idx == FL-1) ? 0 : in_idx + 1;
    end
    @(posedge clk); #1;
    check("frame_cnt", 32'(frame_cnt), 32'(model_fc));
  endtask

  task automatic send(input logic [15:0] re, input logic [15:0] im);
    int unsigned t = 0;
    s_valid = 1'b1; s_re = re; s_im = im;
    while (!s_ready && t < 50) begin step(); t++; end
    check("send_timeout", t, (t < 50) ? t : 0);
    step();
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned t = 0;
    s_valid = 1'b0; m_tready = 1'b1;
    while (exp_q.size() != 0 && t < 64) begin step(); t++; end
    check("drain_left", exp_q.size(), 0);
    step();
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    rst_n = 1'b0; #1;
    check("rst_tvalid", 32'(m_tvalid), 0);
    check("rst_sready", 32'(s_ready), 0);
    check("rst_tlast", 32'(m_tlast), 0);
    check("rst_re", m_tdata_re, 0);
    check("rst_im", m_tdata_im, 0);
    check("rst_fcnt", 32'(frame_cnt), 0);
    @(posedge clk); #4;
    rst_n = 1'b1;
    check("sready_before_edge", 32'(s_ready), 0);
    @(posedge clk); #1;
    check("sready_after_rst", 32'(s_ready), 1);
    exp_q.delete(); out_log.delete();
    in_idx = 0; n_out = 0; model_fc = '0;
  endtask

  initial begin
    // Basic framing
    do_reset();
    m_tready = 1'b1;
    for (int i = 1; i <= 8; i++) send(16'(i), 16'(-i));
    drain();
    check("t1_count", out_log.size(), 8);
    for (int k = 0; k < 8 && k < out_log.size(); k++) begin
      check("t1_re", out_log[k][63:32], 32'(k + 1));
      check("t1_im", out_log[k][31:0], 32'hFFFF_FFFF - 32'(k));
      check("t1_last", 32'(out_log[k][64]), 32'(k == 3 || k == 7));
    end
    check("t1_fcnt", 32'(frame_cnt), 2);

    // Backpressure then drain
    do_reset();
    m_tready = 1'b0;
    for (int i = 1; i <= 4; i++) send(16'h0100 + 16'(i), 16'(i));
    s_valid = 1'b1; s_re = 16'h0105; s_im = 16'd5;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_sready", 32'(s_ready), 0);
      check("bp_hold_re", m_tdata_re, 32'h0000_0101);
      check("bp_hold_im", m_tdata_im, 32'h0000_0001);
    end
    m_tready = 1'b1;
    step();
    check("ready_after_pop", 32'(s_ready), 1);
    step();
    s_re = 16'h0106; s_im = 16'd6;
    step();
    drain();
    check("bp_count", out_log.size(), 6);
    for (int k = 0; k < 6 && k < out_log.size(); k++)
      check("bp_order", out_log[k][63:32], 32'h0000_0101 + 32'(k));

    // Reset mid-frame
    do_reset();
    m_tready = 1'b0;
    send(16'h0AAA, 16'h0001);
    send(16'h0BBB, 16'h0002);
    check("pre_rst_tvalid", 32'(m_tvalid), 1);
    do_reset();
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) send(16'h0200 + 16'(i), 16'(i));
    drain();
    check("mf_count", out_log.size(), 4);
    for (int k = 0; k < 4 && k < out_log.size(); k++) begin
      check("mf_re", out_log[k][63:32], 32'h0000_0200 + 32'(k));
      check("mf_last", 32'(out_log[k][64]), 32'(k == 3));
    end
    check("mf_fcnt", 32'(frame_cnt), 1);

    // frame_cnt wrap and sign-extension boundaries
    do_reset();
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    model_fc = 16'hFFFF;
    check("preload", 32'(frame_cnt), 32'h0000_FFFF);
    m_tready = 1'b1;
    send(16'h8000, 16'h0001);
    send(16'h7FFF, 16'hFFFF);
    send(16'h0001, 16'h8000);
    send(16'h0002, 16'h7FFF);
    drain();
    check("wrap_fcnt", 32'(frame_cnt), 0);
    if (out_log.size() == 4) begin
      check("sext_8000", out_log[0][63:32], 32'hFFFF_8000);
      check("sext_7fff", out_log[1][63:32], 32'h0000_7FFF);
      check("sext_im_ffff", out_log[1][31:0], 32'hFFFF_FFFF);
      check("sext_im_8000", out_log[2][31:0], 32'hFFFF_8000);
      check("sext_im_7fff", out_log[3][31:0], 32'h0000_7FFF);
    end else begin
      check("wrap_count", out_log.size(), 4);
    end

    // Random throughput
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      s_valid  = 1'($urandom_range(0, 1));
      m_tready = 1'($urandom_range(0, 1));
      s_re     = 16'($urandom);
      s_im     = 16'($urandom);
      step();
    end
    drain();
    check("rand_fcnt", 32'(frame_cnt), 32'(16'(n_out / FL)));
    check("rand_nonzero", 32'(n_out > 1000), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
